// File: rtl/cu_interface.sv
// Control-unit side of a tag-sequenced parallel channel: address selection, command and
// status exchange, byte transfer bridged to device-side valid/ready streams.
module cu_interface #(
    parameter logic [7:0] ADDRESS = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  b_bus_out,
    output logic [7:0]  b_bus_in,
    input  logic        b_operational_out,
    input  logic        b_hold_out,
    input  logic        b_select_out,
    input  logic        b_address_out,
    input  logic        b_command_out,
    input  logic        b_service_out,
    input  logic        b_suppress_out,
    output logic        b_operational_in,
    output logic        b_select_in,
    output logic        b_address_in,
    output logic        b_status_in,
    output logic        b_service_in,
    output logic        b_request_in,
    output logic        a_select_out,
    input  logic        a_select_in,
    input  logic        busy,
    input  logic [15:0] xfer_limit,
    input  logic [7:0]  data_send_tdata,
    input  logic        data_send_tvalid,
    output logic        data_send_tready,
    output logic [7:0]  data_recv_tdata,
    output logic        data_recv_tvalid,
    input  logic        data_recv_tready,
    output logic [7:0]  command,
    output logic [15:0] xfer_count,
    output logic [3:0]  o_dbg_state
);
    // Streams move a byte on a rising clk edge where valid and ready are both high; a
    // source holds valid and data stable until that edge, ready may depend on valid.
    typedef enum logic [3:0] {
        S_IDLE, S_PASS, S_ADDR_IN, S_CMD_WAIT, S_STATUS_IN, S_STATUS_ACK,
        S_DATA_REQ, S_DATA_ACK, S_END_STATUS, S_END_ACK, S_DISCONNECT
    } state_t;

    state_t      r_state, w_state;
    logic [14:0] r_sync1, r_sync2;
    logic [14:0] w_sync_in;
    logic        r_sel_prev;
    logic [7:0]  r_bus_in, w_bus_in;
    logic        r_op_in, w_op_in, r_sel_in, w_sel_in, r_addr_in, w_addr_in;
    logic        r_status_in, w_status_in, r_service_in, w_service_in;
    logic        r_a_sel, w_a_sel;
    logic [7:0]  r_command, w_command, r_status, w_status, w_init_status;
    logic [15:0] r_count, w_count;
    logic        r_recv_valid, w_recv_valid;
    logic [7:0]  r_recv_data, w_recv_data;
    logic        r_acked, w_acked, r_stop, w_stop;
    logic        w_send_ready;
    logic [7:0]  w_bus;
    logic        w_op, w_hold, w_sel, w_addr, w_cmd, w_svc, w_asel, w_is_read;
    logic        w_unused_suppress;

    assign w_unused_suppress = b_suppress_out;
    assign w_sync_in = {a_select_in, b_service_out, b_command_out, b_address_out,
                        b_select_out, b_hold_out, b_operational_out, b_bus_out};
    assign w_bus     = r_sync2[7:0];
    assign w_op      = r_sync2[8];
    assign w_hold    = r_sync2[9];
    assign w_sel     = r_sync2[10];
    assign w_addr    = r_sync2[11];
    assign w_cmd     = r_sync2[12];
    assign w_svc     = r_sync2[13];
    assign w_asel    = r_sync2[14];
    assign w_is_read = (r_command == 8'h02);

    always_comb begin
        if (busy)                                         w_init_status = 8'h10;
        else if (r_command == 8'h01 || r_command == 8'h02) w_init_status = 8'h00;
        else if (r_command == 8'h03)                       w_init_status = 8'h0C;
        else                                               w_init_status = 8'h0E;
    end

    always_comb begin
        w_state      = r_state;
        w_bus_in     = r_bus_in;
        w_op_in      = r_op_in;
        w_sel_in     = r_sel_in;
        w_addr_in    = r_addr_in;
        w_status_in  = r_status_in;
        w_service_in = r_service_in;
        w_a_sel      = r_a_sel;
        w_command    = r_command;
        w_status     = r_status;
        w_count      = r_count;
        w_recv_valid = r_recv_valid;
        w_recv_data  = r_recv_data;
        w_acked      = r_acked;
        w_stop       = r_stop;
        w_send_ready = 1'b0;
        if (r_recv_valid && data_recv_tready) w_recv_valid = 1'b0;
        case (r_state)
            S_IDLE: if (w_sel && !r_sel_prev) begin
                if (w_hold && w_addr && w_bus == ADDRESS) begin
                    w_op_in   = 1'b1;
                    w_addr_in = 1'b1;
                    w_bus_in  = ADDRESS;
                    w_count   = 16'h0000;
                    w_stop    = 1'b0;
                    w_acked   = 1'b0;
                    w_state   = S_ADDR_IN;
                end else begin
                    w_a_sel = 1'b1;
                    w_state = S_PASS;
                end
            end
            S_PASS: begin
                w_a_sel  = w_sel;
                w_sel_in = w_asel;
                if (!w_sel) begin
                    w_sel_in = 1'b0;
                    w_state  = S_IDLE;
                end
            end
            S_ADDR_IN: if (!w_addr && w_cmd) begin
                w_command = w_bus;
                w_addr_in = 1'b0;
                w_state   = S_CMD_WAIT;
            end
            S_CMD_WAIT: if (!w_cmd) begin
                w_status    = w_init_status;
                w_bus_in    = w_init_status;
                w_status_in = 1'b1;
                w_state     = S_STATUS_IN;
            end
            S_STATUS_IN: if (w_svc || w_cmd) begin
                w_status_in = 1'b0;
                w_state     = S_STATUS_ACK;
            end
            S_STATUS_ACK: if (!w_svc && !w_cmd) begin
                if (r_status != 8'h00)        w_state = S_DISCONNECT;
                else if (xfer_limit == 16'h0) w_state = S_END_STATUS;
                else                          w_state = S_DATA_REQ;
            end
            S_DATA_REQ: if (!w_is_read || data_send_tvalid) begin
                w_send_ready = w_is_read;
                if (w_is_read) w_bus_in = data_send_tdata;
                w_service_in = 1'b1;
                w_state      = S_DATA_ACK;
            end
            S_DATA_ACK: begin
                // r_acked splits the state: first the channel's reply, then its release.
                if (!r_acked) begin
                    if (w_cmd) begin
                        w_service_in = 1'b0;
                        w_stop       = 1'b1;
                        w_acked      = 1'b1;
                    end else if (w_svc) begin
                        w_service_in = 1'b0;
                        w_acked      = 1'b1;
                        if (!w_is_read) begin
                            w_recv_valid = 1'b1;
                            w_recv_data  = w_bus;
                        end
                        if (r_count != 16'hFFFF) w_count = r_count + 16'd1;
                    end
                end else if (!w_svc && !w_cmd && !r_recv_valid) begin
                    w_acked = 1'b0;
                    w_state = (r_stop || r_count == xfer_limit) ? S_END_STATUS : S_DATA_REQ;
                end
            end
            S_END_STATUS: begin
                if (!r_status_in) begin
                    w_bus_in    = 8'h0C;
                    w_status_in = 1'b1;
                end else if (w_svc) begin
                    w_status_in = 1'b0;
                    w_state     = S_END_ACK;
                end
            end
            S_END_ACK: if (!w_svc) w_state = S_DISCONNECT;
            S_DISCONNECT: begin
                w_op_in      = 1'b0;
                w_addr_in    = 1'b0;
                w_status_in  = 1'b0;
                w_service_in = 1'b0;
                w_bus_in     = 8'h00;
                w_state      = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        // A channel that is no longer operational tears the connection down from any state.
        if (!w_op) begin
            w_op_in      = 1'b0;
            w_sel_in     = 1'b0;
            w_addr_in    = 1'b0;
            w_status_in  = 1'b0;
            w_service_in = 1'b0;
            w_a_sel      = 1'b0;
            w_bus_in     = 8'h00;
            w_recv_valid = 1'b0;
            w_acked      = 1'b0;
            w_stop       = 1'b0;
            w_state      = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_sel_prev   <= 1'b0;
            r_state      <= S_IDLE;
            r_bus_in     <= 8'h00;
            r_op_in      <= 1'b0;
            r_sel_in     <= 1'b0;
            r_addr_in    <= 1'b0;
            r_status_in  <= 1'b0;
            r_service_in <= 1'b0;
            r_a_sel      <= 1'b0;
            r_command    <= 8'h00;
            r_status     <= 8'h00;
            r_count      <= 16'h0000;
            r_recv_valid <= 1'b0;
            r_recv_data  <= 8'h00;
            r_acked      <= 1'b0;
            r_stop       <= 1'b0;
        end else begin
            r_sync1      <= w_sync_in;
            r_sync2      <= r_sync1;
            r_sel_prev   <= w_sel;
            r_state      <= w_state;
            r_bus_in     <= w_bus_in;
            r_op_in      <= w_op_in;
            r_sel_in     <= w_sel_in;
            r_addr_in    <= w_addr_in;
            r_status_in  <= w_status_in;
            r_service_in <= w_service_in;
            r_a_sel      <= w_a_sel;
            r_command    <= w_command;
            r_status     <= w_status;
            r_count      <= w_count;
            r_recv_valid <= w_recv_valid;
            r_recv_data  <= w_recv_data;
            r_acked      <= w_acked;
            r_stop       <= w_stop;
        end
    end

    assign b_bus_in         = r_bus_in;
    assign b_operational_in = r_op_in;
    assign b_select_in      = r_sel_in;
    assign b_address_in     = r_addr_in;
    assign b_status_in      = r_status_in;
    assign b_service_in     = r_service_in;
    assign b_request_in     = 1'b0;
    assign a_select_out     = r_a_sel;
    assign data_send_tready = w_send_ready;
    assign data_recv_tdata  = r_recv_data;
    assign data_recv_tvalid = r_recv_valid;
    assign command          = r_command;
    assign xfer_count       = r_count;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_cu_interface.sv
// Bench for cu_interface: a channel driver plays the tag protocol, device-side stream
// models feed and drain bytes, and a transaction-level model predicts every outcome.
module tb_cu_interface;
    localparam logic [7:0] DEV_ADDR = 8'h1A;
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam int T_OP = 0, T_SEL = 1, T_ADDR = 2, T_ST = 3, T_SVC = 4;

    logic        clk, reset;
    logic [7:0]  b_bus_out, b_bus_in;
    logic        b_operational_out, b_hold_out, b_select_out, b_address_out;
    logic        b_command_out, b_service_out, b_suppress_out;
    logic        b_operational_in, b_select_in, b_address_in, b_status_in;
    logic        b_service_in, b_request_in;
    logic        a_select_out, a_select_in, busy;
    logic [15:0] xfer_limit, xfer_count;
    logic [7:0]  data_send_tdata, data_recv_tdata, command;
    logic        data_send_tvalid, data_send_tready, data_recv_tvalid, data_recv_tready;
    logic [3:0]  o_dbg_state;

    cu_interface #(.ADDRESS(DEV_ADDR)) dut (
        .clk(clk), .reset(reset),
        .b_bus_out(b_bus_out), .b_bus_in(b_bus_in),
        .b_operational_out(b_operational_out), .b_hold_out(b_hold_out),
        .b_select_out(b_select_out), .b_address_out(b_address_out),
        .b_command_out(b_command_out), .b_service_out(b_service_out),
        .b_suppress_out(b_suppress_out),
        .b_operational_in(b_operational_in), .b_select_in(b_select_in),
        .b_address_in(b_address_in), .b_status_in(b_status_in),
        .b_service_in(b_service_in), .b_request_in(b_request_in),
        .a_select_out(a_select_out), .a_select_in(a_select_in),
        .busy(busy), .xfer_limit(xfer_limit),
        .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
        .data_send_tready(data_send_tready),
        .data_recv_tdata(data_recv_tdata), .data_recv_tvalid(data_recv_tvalid),
        .data_recv_tready(data_recv_tready),
        .command(command), .xfer_count(xfer_count), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] rd_src[32];
    logic [7:0] wr_src[32];
    int  rd_idx = 0;
    int  svc_rises = 0;
    int  op_cycles = 0;
    bit  req_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int w);
        case (w)
            T_OP:    return b_operational_in;
            T_SEL:   return b_select_in;
            T_ADDR:  return b_address_in;
            T_ST:    return b_status_in;
            T_SVC:   return b_service_in;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int w, input logic val, input string tag);
        int n = 0;
        while (get_sig(w) !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, get_sig(w)}, {31'd0, val});
    endtask

    // Initial status the unit must present, straight from the command rules.
    function automatic logic [7:0] exp_init_status(input bit bsy, input logic [7:0] cmd);
        if (bsy) return 8'h10;
        case (cmd)
            8'h01, 8'h02: return 8'h00;
            8'h03:        return 8'h0C;
            default:      return 8'h0E;
        endcase
    endfunction

    // device read source: holds valid until taken, random gaps between bytes
    logic src_hs = 1'b0;
    initial begin
        data_send_tvalid = 1'b0;
        data_send_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (src_hs) begin
                rd_idx++;
                data_send_tvalid = 1'b0;
            end
            if (!data_send_tvalid) data_send_tvalid = ($urandom_range(0, 2) != 0);
            data_send_tdata = rd_src[rd_idx % 32];
            #1;
            src_hs = data_send_tvalid && data_send_tready;
        end
    end

    // device write sink with random back-pressure
    logic       snk_hs = 1'b0;
    logic [7:0] snk_data = 8'h00;
    initial begin
        data_recv_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (snk_hs) got_q.push_back(snk_data);
            data_recv_tready = ($urandom_range(0, 3) != 0);
            #1;
            snk_hs   = data_recv_tvalid && data_recv_tready;
            snk_data = data_recv_tdata;
        end
    end

    initial begin : monitor
        logic svc_prev;
        svc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (b_service_in && !svc_prev) svc_rises++;
            svc_prev = b_service_in;
            if (b_operational_in) op_cycles++;
            if (b_request_in) req_seen = 1'b1;
        end
    end

    task automatic deselect();
        b_select_out  = 1'b0;
        b_hold_out    = 1'b0;
        b_address_out = 1'b0;
        a_select_in   = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // One complete channel selection; drop_at >= 0 drops operational_out at that byte.
    task automatic run_cmd(input logic [7:0] sel_addr, input logic [7:0] cmd, input bit bsy,
                           input int limit, input int stop_after, input int drop_at,
                           input string nm);
        logic [7:0] init_st, e, g;
        int exp_n, base_svc, base_op, i, n;
        bit stopped, is_rd;
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            rd_src[k] = 8'($urandom);
            wr_src[k] = 8'($urandom);
        end
        rd_idx     = 0;
        busy       = bsy;
        xfer_limit = 16'(limit);
        base_svc   = svc_rises;
        base_op    = op_cycles;
        b_bus_out     = sel_addr;
        b_hold_out    = 1'b1;
        b_address_out = 1'b1;
        @(negedge clk);
        b_select_out = 1'b1;
        if (sel_addr != DEV_ADDR) begin
            a_select_in = 1'b1;
            repeat (8) @(negedge clk);
            check_eq({nm, " a_select_out"}, {31'd0, a_select_out}, 1);
            check_eq({nm, " b_select_in"}, {31'd0, b_select_in}, 1);
            deselect();
            check_eq({nm, " a_select_out low"}, {31'd0, a_select_out}, 0);
            check_eq({nm, " op_in cycles"}, op_cycles - base_op, 0);
            check_eq({nm, " state"}, {28'd0, o_dbg_state}, {28'd0, ST_IDLE});
            return;
        end
        wait_sig(T_ADDR, 1'b1, {nm, " address_in up"});
        check_eq({nm, " addr echo"}, {24'd0, b_bus_in}, {24'd0, DEV_ADDR});
        check_eq({nm, " op_in"}, {31'd0, b_operational_in}, 1);
        b_address_out = 1'b0;
        b_bus_out     = cmd;
        b_command_out = 1'b1;
        wait_sig(T_ADDR, 1'b0, {nm, " address_in down"});
        check_eq({nm, " command"}, {24'd0, command}, {24'd0, cmd});
        b_command_out = 1'b0;
        wait_sig(T_ST, 1'b1, {nm, " status_in up"});
        init_st = exp_init_status(bsy, cmd);
        check_eq({nm, " init status"}, {24'd0, b_bus_in}, {24'd0, init_st});
        b_service_out = 1'b1;
        wait_sig(T_ST, 1'b0, {nm, " status_in down"});
        b_service_out = 1'b0;
        is_rd   = (cmd == 8'h02);
        exp_n   = 0;
        stopped = 1'b0;
        if (init_st == 8'h00) begin
            exp_n   = (stop_after < limit) ? stop_after : limit;
            stopped = (stop_after < limit);
            for (int k = 0; k < exp_n; k++) exp_q.push_back(is_rd ? rd_src[k] : wr_src[k]);
            i = 0;
            for (int it = 0; it < 40; it++) begin
                n = 0;
                while (!b_service_in && !b_status_in && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!b_service_in && !b_status_in) begin
                    check_eq({nm, " data tag"}, {31'd0, b_service_in | b_status_in}, 1);
                    break;
                end
                if (b_status_in) break;
                if (i == drop_at) begin
                    b_operational_out = 1'b0;
                    repeat (4) @(negedge clk);
                    check_eq({nm, " tags cleared"}, {26'd0, b_operational_in, b_select_in,
                             b_address_in, b_status_in, b_service_in, b_request_in}, 0);
                    check_eq({nm, " state"}, {28'd0, o_dbg_state}, {28'd0, ST_IDLE});
                    check_eq({nm, " recv_tvalid"}, {31'd0, data_recv_tvalid}, 0);
                    b_select_out = 1'b0;
                    b_hold_out = 1'b0;
                    b_address_out = 1'b0;
                    b_operational_out = 1'b1;
                    repeat (6) @(negedge clk);
                    return;
                end
                if (i == stop_after) begin
                    b_command_out = 1'b1;
                    wait_sig(T_SVC, 1'b0, {nm, " stop service_in down"});
                    b_command_out = 1'b0;
                end else begin
                    if (is_rd) got_q.push_back(b_bus_in);
                    else b_bus_out = wr_src[i];
                    b_service_out = 1'b1;
                    wait_sig(T_SVC, 1'b0, {nm, " service_in down"});
                    b_service_out = 1'b0;
                    i++;
                end
            end
            check_eq({nm, " end status"}, {24'd0, b_bus_in}, 32'h0C);
            b_service_out = 1'b1;
            wait_sig(T_ST, 1'b0, {nm, " end status_in down"});
            b_service_out = 1'b0;
        end
        wait_sig(T_OP, 1'b0, {nm, " op_in down"});
        check_eq({nm, " bus_in cleared"}, {24'd0, b_bus_in}, 0);
        repeat (3) @(negedge clk);
        check_eq({nm, " xfer_count"}, {16'd0, xfer_count}, exp_n);
        check_eq({nm, " service_in pulses"}, svc_rises - base_svc, exp_n + int'(stopped));
        check_eq({nm, " byte total"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check_eq({nm, " byte"}, {24'd0, g}, {24'd0, e});
        end
        deselect();
        check_eq({nm, " idle"}, {28'd0, o_dbg_state}, {28'd0, ST_IDLE});
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        reset = 1'b1;
        b_bus_out = 8'h00;  b_operational_out = 1'b1; b_hold_out = 1'b0;
        b_select_out = 1'b0; b_address_out = 1'b0; b_command_out = 1'b0;
        b_service_out = 1'b0; b_suppress_out = 1'b0; a_select_in = 1'b0;
        busy = 1'b0; xfer_limit = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("reset tags", {26'd0, b_operational_in, b_select_in, b_address_in,
                 b_status_in, b_service_in, b_request_in}, 0);
        check_eq("reset streams", {29'd0, a_select_out, data_send_tready, data_recv_tvalid}, 0);
        check_eq("reset bus_in", {24'd0, b_bus_in}, 0);
        check_eq("reset command", {24'd0, command}, 0);
        check_eq("reset xfer_count", {16'd0, xfer_count}, 0);
        check_eq("reset state", {28'd0, o_dbg_state}, {28'd0, ST_IDLE});
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_cmd(8'h10,    8'h02, 1'b0, 4,  99, -1, "pass");
        run_cmd(DEV_ADDR, 8'h02, 1'b1, 4,  99, -1, "busy");
        run_cmd(DEV_ADDR, 8'h02, 1'b0, 16, 6,  -1, "rd_stop6");
        run_cmd(DEV_ADDR, 8'h01, 1'b0, 6,  16, -1, "wr_lim6");
        run_cmd(DEV_ADDR, 8'h03, 1'b0, 4,  99, -1, "nop");
        run_cmd(DEV_ADDR, 8'hFF, 1'b0, 4,  99, -1, "bad_cmd");
        run_cmd(DEV_ADDR, 8'h02, 1'b0, 0,  99, -1, "rd_lim0");
        run_cmd(DEV_ADDR, 8'h01, 1'b0, 0,  99, -1, "wr_lim0");
        run_cmd(DEV_ADDR, 8'h01, 1'b0, 10, 99, 2,  "op_drop");

        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 5))
                0, 1:    c = 8'h01;
                2, 3:    c = 8'h02;
                4:       c = 8'h03;
                default: c = 8'($urandom);
            endcase
            run_cmd(($urandom_range(0, 5) == 0) ? 8'($urandom) : DEV_ADDR, c,
                    ($urandom_range(0, 4) == 0), $urandom_range(0, 8),
                    $urandom_range(0, 10), -1, "rand");
        end

        // reset in the middle of a selection, channel deselects while it is held
        b_bus_out = DEV_ADDR;
        b_hold_out = 1'b1;
        b_address_out = 1'b1;
        @(negedge clk);
        b_select_out = 1'b1;
        wait_sig(T_ADDR, 1'b1, "midreset address_in up");
        reset = 1'b1;
        #1;
        check_eq("midreset tags", {26'd0, b_operational_in, b_select_in, b_address_in,
                 b_status_in, b_service_in, b_request_in}, 0);
        check_eq("midreset bus_in", {24'd0, b_bus_in}, 0);
        @(negedge clk);
        b_select_out = 1'b0;
        b_hold_out = 1'b0;
        b_address_out = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("post-reset tags", {26'd0, b_operational_in, b_select_in, b_address_in,
                 b_status_in, b_service_in, b_request_in}, 0);
        check_eq("post-reset state", {28'd0, o_dbg_state}, {28'd0, ST_IDLE});
        check_eq("request_in never", {31'd0, req_seen}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cu_interface.md
CU_INTERFACE -- requirements
Module: cu_interface

Interface
REQ-001 Parameter ADDRESS, default 8'h00: device address this unit responds to on initial selection.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state and outputs.
REQ-004 b_bus_out  in  8  channel bus-out (address/command/write data); b_bus_in  out  8  bus-in (address/status/read data).
REQ-005 b_operational_out, b_hold_out, b_select_out, b_address_out, b_command_out, b_service_out, b_suppress_out  in  1 each  channel outbound tags.
REQ-006 b_operational_in, b_select_in, b_address_in, b_status_in, b_service_in, b_request_in  out  1 each  inbound tags.
REQ-007 a_select_out  out  1  / a_select_in  in  1: select daisy-chain to next unit.
REQ-008 busy  in  1  device busy; xfer_limit  in  16  max bytes device will move this command.
REQ-009 data_send_tdata  in  8 / data_send_tvalid  in  1 / data_send_tready  out  1: read-direction bytes to channel.
REQ-010 data_recv_tdata  out  8 / data_recv_tvalid  out  1 / data_recv_tready  in  1: write-direction bytes from channel.
REQ-011 command  out  8 (latched command byte); xfer_count  out  16 (bytes moved this command).

Function
REQ-012 All b_* and a_select_in inputs SHALL pass a 2-flop synchronizer; each tag response SHALL assert within 4 clk of the causing edge.
REQ-013 States: IDLE, PASS, ADDR_IN, CMD_WAIT, STATUS_IN, STATUS_ACK, DATA_REQ, DATA_ACK, END_STATUS, END_ACK, DISCONNECT.
REQ-014 IDLE: on select_out rising with hold_out=1, address_out=1 and bus_out==ADDRESS -> raise operational_in, address_in, bus_in=ADDRESS, go ADDR_IN; mismatch -> PASS.
REQ-015 PASS: a_select_out follows b_select_out, b_select_in follows a_select_in; return to IDLE when select_out falls.
REQ-016 ADDR_IN: on address_out low and command_out high, latch command=bus_out, drop address_in, go CMD_WAIT.
REQ-017 CMD_WAIT: on command_out low, choose initial status: busy=1 -> 8'h10; command 01 (write) or 02 (read) -> 8'h00; 03 (NOP) -> 8'h0C; other -> 8'h0E; drive bus_in, raise status_in, go STATUS_IN.
REQ-018 STATUS_IN: on service_out or command_out high, drop status_in, go STATUS_ACK; on response low, go DATA_REQ if status 8'h00, else DISCONNECT.
REQ-019 DATA_REQ read: wait data_send_tvalid, pulse data_send_tready 1 clk, bus_in=data, raise service_in; write: raise service_in directly.
REQ-020 DATA_ACK: on service_out high: write -> data_recv_tvalid with bus_out, held until data_recv_tready; xfer_count+1; drop service_in. On command_out high (channel stop): drop service_in, no count, next END_STATUS.
REQ-021 After response falls: xfer_count==xfer_limit or stop -> END_STATUS, else DATA_REQ.
REQ-022 END_STATUS: bus_in=8'h0C, raise status_in; service_out high -> drop status_in (END_ACK); service_out low -> DISCONNECT.
REQ-023 DISCONNECT: drop operational_in, bus_in=0, return IDLE after 1 clk.
REQ-024 xfer_count 16-bit, cleared at each new selection, saturates at 16'hFFFF; xfer_limit=0 on read/write goes straight to END_STATUS.
REQ-025 b_request_in SHALL remain 0; b_suppress_out ignored.
REQ-026 b_operational_out low in any state SHALL force DISCONNECT behaviour next clk (all inbound tags 0, IDLE), discarding any pending data_recv byte.

Reset
REQ-027 During reset: all inbound tags, a_select_out, data_send_tready, data_recv_tvalid = 0; bus_in, command = 8'h00; xfer_count = 0; state IDLE.
REQ-028 Reset deassertion mid-transfer SHALL resume in IDLE with no tag asserted.

Verification
REQ-029 Select address 8'h10, ADDRESS=8'h1a -> a_select_out follows select_out, operational_in never asserts.
REQ-030 Select 8'h1a, busy=1, command 02 -> status 8'h10, then operational_in drops; xfer_count=0.
REQ-031 Read 02, xfer_limit=16, channel stops after 6 -> 6 bytes on bus_in, status 8'h0C, xfer_count=6.
REQ-032 Write 01, xfer_limit=6, channel offers 16 -> 6 bytes on data_recv, status 8'h0C, xfer_count=6.
REQ-033 Command 03 -> status 8'h0C, no service_in; command 8'hFF -> status 8'h0E, disconnect.
REQ-034 operational_out dropped during DATA_ACK -> all inbound tags 0 within 4 clk, state IDLE.
